// File: rtl/conway_ctrl.sv
// conway_ctrl - sequencing controller for the 32x32 Game-of-Life datapath.
//
// Decides when the grid advances a generation (step_en) and when a seed
// pattern is loaded (load_en). Steps and loads are issued only on VGA frame
// boundaries. Provides run/pause/single-step, a frame-based speed divider
// and a generation counter.
//
// Optional feature macro: CONWAY_CTRL_STILL_DETECT_EN
//   defined   : a step that leaves the grid unchanged sets still=1 and
//               auto-pauses free-running mode.
//   undefined : no snapshot register or comparator; still is tied to 0.
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   frame_start  one-cycle pulse at start of each VGA frame
//   run_toggle   one-cycle pulse: toggle run/pause
//   single_step  one-cycle pulse: request one generation while paused
//   load_req     one-cycle pulse: request a seed load (pattern_sel sampled)
//   pattern_sel  seed select (0 clear, 1 glider, 2 blinker, 3 R-pentomino)
//   speed        step period = speed+1 frames
//   grid_pack    current grid state from the datapath
//   step_en      one-cycle pulse: datapath latches next generation
//   load_en      one-cycle pulse: datapath loads load_pattern
//   load_pattern pattern to load, valid with load_en
//   running      free-running mode active
//   gen_count    generations since last load
//   still        last step produced no change
module conway_ctrl #(
    parameter int GRID_BITS = 1024,
    parameter int GEN_W     = 16,
    parameter int SPEED_W   = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frame_start,
    input  logic                 run_toggle,
    input  logic                 single_step,
    input  logic                 load_req,
    input  logic [1:0]           pattern_sel,
    input  logic [SPEED_W-1:0]   speed,
    input  logic [GRID_BITS-1:0] grid_pack,
    output logic                 step_en,
    output logic                 load_en,
    output logic [1:0]           load_pattern,
    output logic                 running,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 still
);

    typedef enum logic [2:0] {
        PAUSED  = 3'd0,
        RUNNING = 3'd1,
        STEP    = 3'd2,
        CHECK   = 3'd3,
        LOAD    = 3'd4
    } state_t;

    state_t state, nxt;

    logic [SPEED_W-1:0] div;
    logic               load_pend;
    logic               step_pend;
    logic               tog_pend;
    logic [1:0]         pat_q;
    logic               still_hit;

    logic               step_en_d;
    logic               load_en_d;
    logic [1:0]         load_pattern_d;
    logic               running_d;
    logic [GEN_W-1:0]   gen_d;
    logic               still_d;

`ifdef CONWAY_CTRL_STILL_DETECT_EN
    logic [GRID_BITS-1:0] prev;

    // Pre-step snapshot; compared in CHECK once the datapath has stepped.
    always_ff @(posedge clk) begin
        if (!resetn)
            prev <= '0;
        else if (state == STEP)
            prev <= grid_pack;
    end

    assign still_hit = (grid_pack == prev);
`else
    logic unused_grid;
    assign unused_grid = ^grid_pack;
    assign still_hit   = 1'b0;
`endif

    // Next-state logic. running doubles as the originating-mode record while
    // the FSM passes through STEP/CHECK.
    always_comb begin
        nxt = state;
        case (state)
            PAUSED: begin
                if (frame_start && load_pend)      nxt = LOAD;
                else if (run_toggle)               nxt = RUNNING;
                else if (frame_start && step_pend) nxt = STEP;
            end
            RUNNING: begin
                if (frame_start && load_pend)          nxt = LOAD;
                else if (run_toggle)                   nxt = PAUSED;
                else if (frame_start && div == speed)  nxt = STEP;
            end
            STEP:  nxt = CHECK;
            CHECK: begin
                // A still result wins over any pending toggle.
                if (still_hit)                                nxt = PAUSED;
                else if (running ^ (tog_pend | run_toggle))   nxt = RUNNING;
                else                                          nxt = PAUSED;
            end
            LOAD:    nxt = PAUSED;
            default: nxt = PAUSED;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        step_en_d      = (nxt == STEP);
        load_en_d      = (nxt == LOAD);
        load_pattern_d = (nxt == LOAD) ? pat_q : 2'b00;
        running_d      = (nxt == RUNNING) ||
                         (running && (nxt == STEP || nxt == CHECK || nxt == LOAD));
        gen_d          = gen_count;
        if (state == LOAD)
            gen_d = '0;
        else if (state == STEP)
            gen_d = gen_count + 1'b1;
        still_d = still;
        if (state == LOAD)
            still_d = 1'b0;
        else if (state == CHECK)
            still_d = still_hit;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= PAUSED;
            step_en      <= 1'b0;
            load_en      <= 1'b0;
            load_pattern <= 2'b00;
            running      <= 1'b0;
            gen_count    <= '0;
            still        <= 1'b0;
        end else begin
            state        <= nxt;
            step_en      <= step_en_d;
            load_en      <= load_en_d;
            load_pattern <= load_pattern_d;
            running      <= running_d;
            gen_count    <= gen_d;
            still        <= still_d;
        end
    end

    // Divider and pending request flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div       <= '0;
            load_pend <= 1'b0;
            step_pend <= 1'b0;
            tog_pend  <= 1'b0;
            pat_q     <= 2'b00;
        end else begin
            // Entering free-running mode from pause restarts the frame count.
            if (nxt == RUNNING && !running)
                div <= '0;
            else if (state == RUNNING && frame_start)
                div <= (div == speed) ? '0 : div + 1'b1;

            if (load_req) begin
                load_pend <= 1'b1;
                pat_q     <= pattern_sel;
            end else if (state == LOAD) begin
                load_pend <= 1'b0;
            end

            if (state == LOAD)
                step_pend <= 1'b0;
            else if (state == PAUSED && nxt == STEP)
                step_pend <= 1'b0;
            else if (state == PAUSED && single_step)
                step_pend <= 1'b1;

            if (state == STEP && run_toggle)
                tog_pend <= 1'b1;
            else if (state == CHECK)
                tog_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conway_ctrl.sv
module tb_conway_ctrl;

    localparam int GB = 1024;
    localparam int GW = 16;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          frame_start = 1'b0;
    logic          run_toggle = 1'b0;
    logic          single_step = 1'b0;
    logic          load_req = 1'b0;
    logic [1:0]    pattern_sel = 2'b00;
    logic [SW-1:0] speed = '0;
    logic [GB-1:0] grid_pack;
    logic          step_en, load_en, running, still;
    logic [1:0]    load_pattern;
    logic [GW-1:0] gen_count;

    conway_ctrl #(.GRID_BITS(GB), .GEN_W(GW), .SPEED_W(SW)) dut (
        .clk(clk), .resetn(resetn), .frame_start(frame_start),
        .run_toggle(run_toggle), .single_step(single_step), .load_req(load_req),
        .pattern_sel(pattern_sel), .speed(speed), .grid_pack(grid_pack),
        .step_en(step_en), .load_en(load_en), .load_pattern(load_pattern),
        .running(running), .gen_count(gen_count), .still(still)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Game-of-Life helpers (environment + model) ----------
    function automatic logic [GB-1:0] pat_grid(input logic [1:0] p);
        logic [GB-1:0] g;
        g = '0;
        case (p)
            2'd1: begin
                g[10*32+11] = 1'b1; g[11*32+12] = 1'b1;
                g[12*32+10] = 1'b1; g[12*32+11] = 1'b1; g[12*32+12] = 1'b1;
            end
            2'd2: begin
                g[11*32+10] = 1'b1; g[11*32+11] = 1'b1; g[11*32+12] = 1'b1;
            end
            2'd3: begin
                g[10*32+11] = 1'b1; g[10*32+12] = 1'b1;
                g[11*32+10] = 1'b1; g[11*32+11] = 1'b1; g[12*32+11] = 1'b1;
            end
            default: g = '0;
        endcase
        return g;
    endfunction

    function automatic logic [GB-1:0] life(input logic [GB-1:0] g);
        logic [GB-1:0] ng;
        ng = '0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 32 &&
                            c + dc >= 0 && c + dc < 32)
                            n += int'(g[(r + dr) * 32 + (c + dc)]);
                ng[r*32+c] = (n == 3) || (g[r*32+c] && n == 2);
            end
        end
        return ng;
    endfunction

    // Datapath stand-in reacting to the controller's pulses.
    always @(posedge clk) begin
        if (!resetn)      grid_pack <= '0;
        else if (load_en) grid_pack <= pat_grid(load_pattern);
        else if (step_en) grid_pack <= life(grid_pack);
    end

    // ---------------- Scoreboard -------------------------------------------
    typedef struct {
        bit            is_load;
        logic [1:0]    pat;
        logic [GW-1:0] gen;
        int            at_cyc;
    } ev_t;
    ev_t sb[$];

    bit            post_pending = 0;
    bit            post_load = 0;
    logic [GW-1:0] post_gen;

    always @(negedge clk) begin
        ev_t e;
        if (post_pending) begin
            chk("gen_after_event", 32'(gen_count), 32'(post_gen));
            if (post_load) chk("running_after_load", 32'(running), 32'd0);
            post_pending = 0;
        end
        if (step_en || load_en) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got step_en=%0b load_en=%0b expected none (cycle %0d)",
                         step_en, load_en, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {30'd0, step_en, load_en}, e.is_load ? 32'd1 : 32'd2);
                chk("pulse_cycle", 32'(cyc), 32'(e.at_cyc));
                if (e.is_load) chk("load_pattern", 32'(load_pattern), 32'(e.pat));
                post_pending = 1;
                post_load    = e.is_load;
                post_gen     = e.gen;
            end
        end
    end

    // ---------------- Reference model state --------------------------------
    bit            m_run, m_lp, m_sp, m_still;
    int            m_n;
    logic [1:0]    m_pat;
    logic [GW-1:0] m_gen;
    logic [GB-1:0] m_grid;

    task automatic model_reset();
        m_run = 0; m_lp = 0; m_sp = 0; m_still = 0;
        m_n = 0; m_pat = 2'b00; m_gen = '0; m_grid = '0;
    endtask

    task automatic model_step(input int at);
        ev_t e;
        logic [GB-1:0] ng;
        m_gen = m_gen + 1'b1;
        ng = life(m_grid);
`ifdef CONWAY_CTRL_STILL_DETECT_EN
        m_still = (ng == m_grid);
        if (m_still) m_run = 0;
`endif
        m_grid = ng;
        e.is_load = 0; e.pat = 2'b00; e.gen = m_gen; e.at_cyc = at;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Stimulus ---------------------------------------------
    task automatic do_frame();
        ev_t e;
        int at;
        chk("running", 32'(running), 32'(m_run));
        chk("gen_count", 32'(gen_count), 32'(m_gen));
        chk("still", 32'(still), 32'(m_still));
        frame_start = 1'b1;
        at = cyc + 1;
        if (m_lp) begin
            m_gen = '0; m_run = 0; m_still = 0; m_lp = 0; m_sp = 0;
            m_grid = pat_grid(m_pat);
            e.is_load = 1; e.pat = m_pat; e.gen = '0; e.at_cyc = at;
            sb.push_back(e);
        end else if (m_run) begin
            m_n++;
            if (m_n == int'(speed) + 1) begin
                m_n = 0;
                model_step(at);
            end
        end else if (m_sp) begin
            m_sp = 0;
            model_step(at);
        end
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_toggle();
        run_toggle = 1'b1;
        m_run = !m_run;
        if (m_run) m_n = 0;
        tick();
        run_toggle = 1'b0;
    endtask

    task automatic do_single();
        single_step = 1'b1;
        if (!m_run) m_sp = 1;
        tick();
        single_step = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] p);
        load_req = 1'b1;
        pattern_sel = p;
        m_lp = 1; m_pat = p;
        tick();
        load_req = 1'b0;
        pattern_sel = 2'(($urandom_range(0, 3)));
    endtask

    // One frame period of 10 cycles; random controls only in the quiet window.
    task automatic slot(input bit rnd);
        do_frame();
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            int r = $urandom_range(0, 11);
            if (!rnd) tick();
            else if (r == 0) do_toggle();
            else if (r == 1 || r == 2) do_single();
            else if (r == 3) do_load(2'($urandom_range(0, 3)));
            else if (r == 4 && !m_run) begin speed = SW'($urandom_range(0, 3)); tick(); end
            else tick();
        end
        tick(); tick(); tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sb.delete();
        model_reset();
        tick();
        for (int k = 0; k < 5; k++) begin
            frame_start = k[0];
            chk("reset_outputs", {8'd0, step_en, load_en, load_pattern, running, still, gen_count}, 32'd0);
            tick();
        end
        frame_start = 1'b0;
        resetn = 1'b1;
        tick(); tick();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Load glider, then run at speed 2 for 9 frames.
        do_load(2'd1);
        slot(0);
        speed = 3'd2;
        do_toggle();
        for (int k = 0; k < 9; k++) slot(0);
        chk("gen_after_9_frames", 32'(gen_count), 32'd3);
        do_toggle();

        // Two single_steps before one frame -> one step; single_step while running ignored.
        do_single(); do_single();
        slot(0); slot(0);
        do_toggle();
        do_single();
        slot(0); slot(0);

        // Load request and a step-due frame coincide: load wins.
        do_load(2'd2);
        slot(0);
        slot(0);

        // Cleared grid, speed 0: still detection (when built in) pauses after one step.
        do_load(2'd0);
        slot(0);
        speed = 3'd0;
        do_toggle();
        for (int k = 0; k < 4; k++) slot(0);
        do_toggle();
        slot(0); slot(0);

        for (int k = 0; k < 120; k++) slot(1);
        do_reset();
        for (int k = 0; k < 120; k++) slot(1);

        for (int k = 0; k < 10; k++) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conway_ctrl.md
# conway_ctrl

Sequencing controller for the 32x32 Game-of-Life grid datapath. It decides when the grid advances one generation and when a seed pattern is loaded. Steps and loads are aligned to VGA frame boundaries, so the display never shows a half-updated frame. It implements run/pause/single-step, a frame-based speed divider and a generation counter, and can optionally auto-pause when the grid reaches a still life.

## Interface
Parameters:
- GRID_BITS, 1024, width of packed grid state (row-major, bit i*32+j)
- GEN_W, 16, generation counter width
- SPEED_W, 3, speed-select width

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of each VGA frame (vsync edge)
- run_toggle  in  1  one-cycle pulse (debounced upstream): toggle run/pause
- single_step  in  1  one-cycle pulse: advance one generation while paused
- load_req  in  1  one-cycle pulse: load seed pattern
- pattern_sel  in  2  seed select (0 clear, 1 glider, 2 blinker, 3 R-pentomino), sampled with load_req
- speed  in  SPEED_W  step period = speed+1 frames
- grid_pack  in  GRID_BITS  current grid state from datapath
- step_en  out  1  one-cycle pulse: datapath latches next generation
- load_en  out  1  one-cycle pulse: datapath loads load_pattern
- load_pattern  out  2  pattern to load, valid with load_en
- running  out  1  free-running mode active
- gen_count  out  GEN_W  generations since last load
- still  out  1  last step produced no change (macro-dependent)

## Operation
- All outputs registered. Reset value of every output and internal register is 0. Reset state is PAUSED.
- States: PAUSED, RUNNING, STEP, CHECK, LOAD.
- Pending flags:
  - load_req sets load_pend and latches pattern_sel. A later load_req before execution overwrites the latched pattern.
  - single_step while PAUSED sets step_pend. It is ignored in any other state.
- run_toggle:
  - In PAUSED: go to RUNNING, clear frame divider.
  - In RUNNING: go to PAUSED.
  - In STEP/CHECK: latched, applied on the return to PAUSED/RUNNING.
- Frame divider (SPEED_W bits) counts frame_start pulses in RUNNING. When divider == speed and frame_start arrives: clear divider, go to STEP. A speed change takes effect on the next comparison.
- frame_start with load_pend, in PAUSED or RUNNING: go to LOAD. Load beats step at the same frame.
- frame_start in PAUSED with step_pend: go to STEP, clear step_pend.
- LOAD (1 cycle):
  - load_en=1, load_pattern=latched value.
  - Clear gen_count, still, running, load_pend, step_pend.
  - Next state PAUSED.
- STEP (1 cycle):
  - step_en=1, gen_count+=1 (wraps 2^GEN_W-1 -> 0).
  - Snapshot grid_pack (pre-step) into prev.
  - Next state CHECK.
- CHECK (1 cycle): compare grid_pack against prev, then return to the originating mode (RUNNING or PAUSED).
- Reset mid-operation: pending flags dropped, no step_en/load_en emitted after the reset cycle.

## Timing
- frame_start in cycle t that triggers a step -> step_en high in t+1, gen_count updated t+2, CHECK in t+2.
- frame_start in t that triggers a load -> load_en high in t+1, gen_count=0 and running=0 visible t+2.
- Step period while running: exactly (speed+1) frames. The first step comes (speed+1) frames after entering RUNNING.
- Min spacing between step_en pulses: 3 cycles. frame_start during STEP/CHECK is ignored for divider purposes.
- running output changes the cycle after the causing event.

## Configuration
- CONWAY_CTRL_STILL_DETECT_EN defined:
  - CHECK sets still=1 if grid_pack == prev.
  - A still result forces running=0 (state PAUSED) at t+3, and wins over a simultaneous run_toggle.
  - still clears on the next step that changes the grid, or on load.
  - A run_toggle while still=1 resumes running.
- Undefined: prev register and comparator omitted, still tied to 0, and CHECK only returns to the originating mode.

## Test plan
- Reset: hold resetn=0 with frame_start pulsing -> all outputs 0, no step_en; release -> state PAUSED.
- load_req pattern_sel=1, then frame_start -> single load_en with load_pattern=1 one cycle after frame_start; gen_count=0, running=0.
- run_toggle, speed=2, 9 frame_starts -> exactly 3 step_en pulses, each one cycle after frames 3, 6 and 9; gen_count=3.
- While paused: single_step twice before one frame_start -> one step_en, gen_count+1. single_step while running -> no extra step.
- load_req and a step-due frame_start in the same frame -> load_en only, no step_en, running=0.
- Macro on: load blinker-free still block (pattern 0 cleared grid), run with speed=0 -> first step, still=1 at CHECK, running=0 next cycle, no further step_en. Macro off -> steps continue, still=0.
